sc_shift_controller: RTL and testbench

//  Sequences the left/right shift datapath for the player-car lane register.

---
 rtl/sc_shift_controller_pkg.sv | 13 +
 rtl/sc_tick_prescaler.sv | 28 ++
 rtl/sc_shift_controller.sv | 155 +++++++++++++++
 tb/tb_sc_shift_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_shift_controller_pkg.sv
// Shared types and constants for the player-car lane shift controller.
package sc_shift_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2
  } scState_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

endpackage

// File: rtl/sc_tick_prescaler.sv
// Clearable step-rate counter; tick is high while the count sits at PRESCALE-1.
module sc_tick_prescaler #(
  parameter int PRESCALE = 12500000
) (
  input  logic sc_tick_prescaler_CLOCK_50,
  input  logic sc_tick_prescaler_RESET_InLow,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] countReg;

  assign tick = enable && (countReg == CW'(PRESCALE - 1));

  always_ff @(posedge sc_tick_prescaler_CLOCK_50 or negedge sc_tick_prescaler_RESET_InLow) begin
    if (!sc_tick_prescaler_RESET_InLow) begin
      countReg <= '0;
    end else if (clear) begin
      countReg <= '0;
    end else if (enable && !tick) begin
      countReg <= countReg + CW'(1);
    end
  end

endmodule

// File: rtl/sc_shift_controller.sv
// Lane register owner: rate-limited single-step shifts with edge saturation and load override.
// Build option SC_SHIFT_CONTROLLER_WRAP_EN: edges rotate instead of saturating.
module sc_shift_controller
  import sc_shift_controller_pkg::*;
#(
  parameter int                   DATAWIDTH  = 4,
  parameter int                   PRESCALE   = 12500000,
  parameter logic [DATAWIDTH-1:0] INIT_VALUE = DATAWIDTH'(1)
) (
  input  logic                 sc_shift_controller_CLOCK_50,
  input  logic                 sc_shift_controller_RESET_InLow,
  input  logic                 sc_shift_controller_left_In,
  input  logic                 sc_shift_controller_right_In,
  input  logic                 sc_shift_controller_load_In,
  input  logic [DATAWIDTH-1:0] sc_shift_controller_data_InBUS,
  output logic [DATAWIDTH-1:0] sc_shift_controller_data_OutBUS,
  output logic                 sc_shift_controller_dir_Out,
  output logic                 sc_shift_controller_step_Out,
  output logic                 sc_shift_controller_edge_Out
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ARM   = ARM;
  localparam logic [1:0] S_SHIFT = SHIFT;

`ifdef SC_SHIFT_CONTROLLER_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  logic [1:0]           stateReg, stateNext;
  logic                 armDirReg, armDirNext;
  logic [DATAWIDTH-1:0] dataReg, dataNext;
  logic                 dirReg, dirNext;
  logic                 stepReg, stepNext;
  logic                 edgeReg, edgeNext;

  logic                 reqValid, reqDir, dirChanged, tick, blocked;
  logic [DATAWIDTH-1:0] shiftLeft, shiftRight;

  assign reqValid   = sc_shift_controller_left_In ^ sc_shift_controller_right_In;
  assign reqDir     = sc_shift_controller_left_In ? DIR_LEFT : DIR_RIGHT;
  assign dirChanged = reqDir != armDirReg;

  sc_tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) uPrescaler (
    .sc_tick_prescaler_CLOCK_50  (sc_shift_controller_CLOCK_50),
    .sc_tick_prescaler_RESET_InLow(sc_shift_controller_RESET_InLow),
    .clear                       ((stateReg != S_ARM) || sc_shift_controller_load_In),
    .enable                      (stateReg == S_ARM),
    .tick                        (tick)
  );

  // Per-bit neighbour selection; only the end bits differ between saturate and rotate.
  genvar gi;
  generate
    for (gi = 0; gi < DATAWIDTH; gi++) begin : gLane
      if (gi == 0) begin : gLsb
        assign shiftLeft[gi] = WRAP_EN ? dataReg[DATAWIDTH-1] : 1'b0;
      end else begin : gLowFill
        assign shiftLeft[gi] = dataReg[gi-1];
      end
      if (gi == DATAWIDTH - 1) begin : gMsb
        assign shiftRight[gi] = WRAP_EN ? dataReg[0] : 1'b0;
      end else begin : gHighFill
        assign shiftRight[gi] = dataReg[gi+1];
      end
    end
  endgenerate

  // A zero register has neither end bit set, so it is never blocked.
  assign blocked = !WRAP_EN && ((armDirReg == DIR_LEFT) ? dataReg[DATAWIDTH-1] : dataReg[0]);

  always_comb begin
    stateNext  = stateReg;
    armDirNext = armDirReg;
    dataNext   = dataReg;
    dirNext    = dirReg;
    stepNext   = 1'b0;
    edgeNext   = edgeReg;

    if (!reqValid || dirChanged) begin
      edgeNext = 1'b0;
    end

    case (stateReg)
      S_IDLE: begin
        if (reqValid) begin
          stateNext  = S_ARM;
          armDirNext = reqDir;
        end
      end
      S_ARM: begin
        if (!reqValid || dirChanged) begin
          stateNext = S_IDLE;
        end else if (tick) begin
          // The step is committed on entry to SHIFT so its pulse is visible during SHIFT.
          stateNext = S_SHIFT;
          if (blocked) begin
            edgeNext = 1'b1;
          end else begin
            dataNext = (armDirReg == DIR_LEFT) ? shiftLeft : shiftRight;
            dirNext  = armDirReg;
            stepNext = 1'b1;
            edgeNext = 1'b0;
          end
        end
      end
      S_SHIFT: begin
        if (reqValid) begin
          stateNext  = S_ARM;
          armDirNext = reqDir;
        end else begin
          stateNext = S_IDLE;
        end
      end
      default: begin
        stateNext = S_IDLE;
      end
    endcase

    if (sc_shift_controller_load_In) begin
      dataNext  = sc_shift_controller_data_InBUS;
      stateNext = S_IDLE;
      stepNext  = 1'b0;
      edgeNext  = 1'b0;
    end
  end

  always_ff @(posedge sc_shift_controller_CLOCK_50 or negedge sc_shift_controller_RESET_InLow) begin
    if (!sc_shift_controller_RESET_InLow) begin
      stateReg  <= S_IDLE;
      armDirReg <= DIR_RIGHT;
      dataReg   <= INIT_VALUE;
      dirReg    <= DIR_RIGHT;
      stepReg   <= 1'b0;
      edgeReg   <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      armDirReg <= armDirNext;
      dataReg   <= dataNext;
      dirReg    <= dirNext;
      stepReg   <= stepNext;
      edgeReg   <= edgeNext;
    end
  end

  assign sc_shift_controller_data_OutBUS = dataReg;
  assign sc_shift_controller_dir_Out     = dirReg;
  assign sc_shift_controller_step_Out    = stepReg;
  assign sc_shift_controller_edge_Out    = edgeReg;

endmodule

// File: tb/tb_sc_shift_controller.sv
// Scoreboard bench for sc_shift_controller (PRESCALE=4); step pulses are matched against queued expectations.
module tb_sc_shift_controller;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       load = 1'b0;
  logic [3:0] dataIn = 4'b0000;
  logic [3:0] dataOut;
  logic       dirOut, stepOut, edgeOut;

  int vectors = 0;
  int miscompares = 0;
  int edgeNum = 0;

  typedef struct {
    int         at;
    logic [3:0] data;
    logic       dir;
  } exp_t;

  exp_t expQ[$];

`ifdef SC_SHIFT_CONTROLLER_WRAP_EN
  localparam logic [3:0] T2_DATA = 4'b1000;
  localparam logic [3:0] T3_DATA = 4'b0100;
`else
  localparam logic [3:0] T2_DATA = 4'b0100;
  localparam logic [3:0] T3_DATA = 4'b0010;
`endif

  sc_shift_controller #(
    .DATAWIDTH (4),
    .PRESCALE  (4),
    .INIT_VALUE(4'b0001)
  ) dut (
    .sc_shift_controller_CLOCK_50   (clk),
    .sc_shift_controller_RESET_InLow(rstN),
    .sc_shift_controller_left_In    (left),
    .sc_shift_controller_right_In   (right),
    .sc_shift_controller_load_In    (load),
    .sc_shift_controller_data_InBUS (dataIn),
    .sc_shift_controller_data_OutBUS(dataOut),
    .sc_shift_controller_dir_Out    (dirOut),
    .sc_shift_controller_step_Out   (stepOut),
    .sc_shift_controller_edge_Out   (edgeOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgeNum++;

  task automatic expectStep(input int at, input logic [3:0] d, input logic dr);
    exp_t e;
    e.at   = at;
    e.data = d;
    e.dir  = dr;
    expQ.push_back(e);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s edge=%0d actual=%b required=%b", name, edgeNum, act, req);
    end else begin
      $display("pass %s edge=%0d value=%b", name, edgeNum, act);
    end
  endtask

  task automatic gotoEdge(input int target);
    while (edgeNum < target) @(negedge clk);
  endtask

  // Monitor: every step pulse must match the head of the queue in data, dir and edge index.
  always @(negedge clk) begin
    if (rstN && stepOut) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_step edge=%0d data=%b dir=%b required=no step", edgeNum, dataOut, dirOut);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (dataOut !== e.data || dirOut !== e.dir || edgeNum != e.at || edgeOut !== 1'b0) begin
          miscompares++;
          $display("FAIL step actual edge=%0d data=%b dir=%b edgeOut=%b required edge=%0d data=%b dir=%b edgeOut=0",
                   edgeNum, dataOut, dirOut, edgeOut, e.at, e.data, e.dir);
        end else begin
          $display("pass step edge=%0d data=%b dir=%b", edgeNum, dataOut, dirOut);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d actual=running required=finished", edgeNum);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, q, r, s, u;

    // Reset values, with left already held.
    left = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", dataOut, 4'b0001);
    check("reset_dir", {3'b0, dirOut}, 4'd0);
    check("reset_step", {3'b0, stepOut}, 4'd0);
    check("reset_edge", {3'b0, edgeOut}, 4'd0);

    // T1: first step 4 edges after the request is first sampled, then every 5.
    rstN = 1'b1;
    p = edgeNum;
    expectStep(p + 5, 4'b0010, 1'b1);
    expectStep(p + 10, 4'b0100, 1'b1);
    expectStep(p + 15, 4'b1000, 1'b1);
`ifdef SC_SHIFT_CONTROLLER_WRAP_EN
    expectStep(p + 20, 4'b0001, 1'b1);
`endif
    gotoEdge(p + 19);
    check("t1_edge_low", {3'b0, edgeOut}, 4'd0);

    // T2: blocked at the MSB, then reverse.
    gotoEdge(p + 20);
`ifndef SC_SHIFT_CONTROLLER_WRAP_EN
    check("t2_blocked_edge", {3'b0, edgeOut}, 4'd1);
    check("t2_blocked_data", dataOut, 4'b1000);
    check("t2_blocked_step", {3'b0, stepOut}, 4'd0);
    check("t2_blocked_dir", {3'b0, dirOut}, 4'd1);
`endif
    gotoEdge(p + 21);
    left  = 1'b0;
    right = 1'b1;
    expectStep(p + 27, T2_DATA, 1'b0);
    gotoEdge(p + 22);
    check("t2_edge_cleared", {3'b0, edgeOut}, 4'd0);
    gotoEdge(p + 27);
    right = 1'b0;

    // T3: both requests high is no request; a later single request arms from scratch.
    gotoEdge(p + 29);
    left  = 1'b1;
    right = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_data_hold", dataOut, T2_DATA);
    check("t3_edge", {3'b0, edgeOut}, 4'd0);
    q = edgeNum;
    left = 1'b0;
    expectStep(q + 5, T3_DATA, 1'b0);

    // T4: load coincides with an expiring count and wins.
    gotoEdge(q + 9);
    load   = 1'b1;
    dataIn = 4'b1000;
    expectStep(q + 15, 4'b0100, 1'b0);
    gotoEdge(q + 10);
    load = 1'b0;
    check("t4_load_data", dataOut, 4'b1000);
    check("t4_load_step", {3'b0, stepOut}, 4'd0);
    gotoEdge(q + 15);
    right = 1'b0;
    left  = 1'b1;

    // T5: asynchronous reset in the middle of an ARM count.
    gotoEdge(q + 17);
    @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    check("t5_async_data", dataOut, 4'b0001);
    check("t5_async_dir", {3'b0, dirOut}, 4'd0);
    check("t5_async_edge", {3'b0, edgeOut}, 4'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    r = edgeNum;
    expectStep(r + 5, 4'b0010, 1'b1);
    gotoEdge(r + 4);
    check("t5_no_early_step", dataOut, 4'b0001);
    gotoEdge(r + 5);
    left = 1'b0;

    // Zero register: never blocked, still pulses step.
    gotoEdge(r + 6);
    load   = 1'b1;
    dataIn = 4'b0000;
    gotoEdge(r + 7);
    load  = 1'b0;
    right = 1'b1;
    check("zero_load", dataOut, 4'b0000);
    s = edgeNum;
    expectStep(s + 5, 4'b0000, 1'b0);
    expectStep(s + 10, 4'b0000, 1'b0);
    gotoEdge(s + 10);
    right = 1'b0;
    check("zero_edge", {3'b0, edgeOut}, 4'd0);

    // T6: MSB/LSB boundary in the configured mode.
    gotoEdge(s + 12);
    load = 1'b1;
`ifdef SC_SHIFT_CONTROLLER_WRAP_EN
    dataIn = 4'b1000;
    gotoEdge(s + 13);
    load = 1'b0;
    left = 1'b1;
    u = edgeNum;
    expectStep(u + 5, 4'b0001, 1'b1);
    gotoEdge(u + 5);
    check("t6_wrap_edge", {3'b0, edgeOut}, 4'd0);
    left = 1'b0;
`else
    dataIn = 4'b0001;
    gotoEdge(s + 13);
    load  = 1'b0;
    right = 1'b1;
    u = edgeNum;
    gotoEdge(u + 4);
    check("t6_pre_block_edge", {3'b0, edgeOut}, 4'd0);
    gotoEdge(u + 5);
    check("t6_right_blocked_edge", {3'b0, edgeOut}, 4'd1);
    check("t6_right_blocked_data", dataOut, 4'b0001);
    gotoEdge(u + 6);
    right = 1'b0;
    gotoEdge(u + 7);
    check("t6_edge_release", {3'b0, edgeOut}, 4'd0);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 4'(expQ.size()), 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
